// File: rtl/reg4_write_arbiter.sv
// Round-robin write arbiter for a shared 4-bit register with guard gap.
// Optional write counter output enabled by macro REG4_ARB_WRCOUNT_EN.
module reg4_write_arbiter #(
    parameter int unsigned GUARD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] din0,
    input  logic [3:0] din1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] reg_pi,
    output logic       reg_cen,
`ifdef REG4_ARB_WRCOUNT_EN
    output logic [7:0] wr_count,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR0,
        S_WR1,
        S_GUARD
    } state_t;

    localparam logic [3:0] GLOAD = (GUARD == 0) ? 4'd0 : 4'(GUARD - 1);

    state_t     state_q;
    logic [3:0] hold_q;
    logic [3:0] cnt_q;
    logic       last_q;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       cen_q;
    logic       take0;
    logic       take1;

    // A tie goes to whoever did not own the previous write.
    always_comb begin
        take0 = req0 & (~req1 | last_q);
        take1 = req1 & (~req0 | ~last_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= 4'd0;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cen_q   <= 1'b0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            cen_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (take0) begin
                        state_q <= S_WR0;
                        hold_q  <= din0;
                        gnt0_q  <= 1'b1;
                        cen_q   <= 1'b1;
                        last_q  <= 1'b0;
                    end else if (take1) begin
                        state_q <= S_WR1;
                        hold_q  <= din1;
                        gnt1_q  <= 1'b1;
                        cen_q   <= 1'b1;
                        last_q  <= 1'b1;
                    end
                end
                S_WR0, S_WR1: begin
                    if (GUARD != 0) begin
                        state_q <= S_GUARD;
                        cnt_q   <= GLOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_GUARD: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign reg_cen = cen_q;
    assign reg_pi  = hold_q;
    assign busy    = (state_q != S_IDLE);

`ifdef REG4_ARB_WRCOUNT_EN
    logic [7:0] wrcnt_q;
    logic [7:0] wrcnt_d;

    always_comb begin
        wrcnt_d = wrcnt_q;
        if (state_q == S_WR0 || state_q == S_WR1) begin
            wrcnt_d = wrcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrcnt_q <= 8'd0;
        end else begin
            wrcnt_q <= wrcnt_d;
        end
    end

    assign wr_count = wrcnt_q;
`endif

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Directed bench for reg4_write_arbiter: GUARD=1 instance (a_*)
// and GUARD=0 instance (b_*).
module tb_reg4_write_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req0, a_req1, a_gnt0, a_gnt1, a_reg_cen, a_busy;
    logic [3:0] a_din0, a_din1, a_reg_pi;
    logic       b_req0, b_req1, b_gnt0, b_gnt1, b_reg_cen, b_busy;
    logic [3:0] b_din0, b_din1, b_reg_pi;
`ifdef REG4_ARB_WRCOUNT_EN
    logic [7:0] a_wr_count, b_wr_count;
`endif

    int nchk = 0;
    int nfail = 0;

    reg4_write_arbiter #(.GUARD(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(a_req0), .req1(a_req1),
        .din0(a_din0), .din1(a_din1),
        .gnt0(a_gnt0), .gnt1(a_gnt1),
        .reg_pi(a_reg_pi), .reg_cen(a_reg_cen),
`ifdef REG4_ARB_WRCOUNT_EN
        .wr_count(a_wr_count),
`endif
        .busy(a_busy)
    );

    reg4_write_arbiter #(.GUARD(0)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .req1(b_req1),
        .din0(b_din0), .din1(b_din1),
        .gnt0(b_gnt0), .gnt1(b_gnt1),
        .reg_pi(b_reg_pi), .reg_cen(b_reg_cen),
`ifdef REG4_ARB_WRCOUNT_EN
        .wr_count(b_wr_count),
`endif
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed vector for A: {gnt1,gnt0,reg_cen,busy,reg_pi}
    function automatic logic [7:0] a_vec();
        return {a_gnt1, a_gnt0, a_reg_cen, a_busy, a_reg_pi};
    endfunction

    function automatic logic [7:0] b_vec();
        return {b_gnt1, b_gnt0, b_reg_cen, b_busy, b_reg_pi};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        nchk++;
        if (a_vec() !== 8'h00) begin
            nfail++;
            $display("FAIL reset_a: got %h want %h", a_vec(), 8'h00);
        end
        nchk++;
        if (b_vec() !== 8'h00) begin
            nfail++;
            $display("FAIL reset_b: got %h want %h", b_vec(), 8'h00);
        end
        rst = 1'b0;
        tick();
        nchk++;
        if (a_vec() !== 8'h00) begin
            nfail++;
            $display("FAIL idle_noreq: got %h want %h", a_vec(), 8'h00);
        end
    endtask

    task automatic test_single();
        a_req0 = 1'b1;
        a_din0 = 4'hA;
        tick();
        nchk++;
        if (a_vec() !== 8'b0111_1010) begin
            nfail++;
            $display("FAIL single_wr: got %b want %b", a_vec(), 8'b0111_1010);
        end
        a_req0 = 1'b0;
        a_din0 = 4'h0;
        tick();
        nchk++;
        if (a_vec() !== 8'b0001_1010) begin
            nfail++;
            $display("FAIL single_guard: got %b want %b", a_vec(), 8'b0001_1010);
        end
        tick();
        nchk++;
        if (a_vec() !== 8'b0000_1010) begin
            nfail++;
            $display("FAIL single_idle: got %b want %b", a_vec(), 8'b0000_1010);
        end
    endtask

    task automatic test_tie();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_req0 = 1'b1;
        a_req1 = 1'b1;
        a_din0 = 4'h3;
        a_din1 = 4'hC;
        tick();
        nchk++;
        if (a_vec() !== 8'b0111_0011) begin
            nfail++;
            $display("FAIL tie_first: got %b want %b", a_vec(), 8'b0111_0011);
        end
        a_req0 = 1'b0;
        tick();
        nchk++;
        if (a_vec() !== 8'b0001_0011) begin
            nfail++;
            $display("FAIL tie_guard: got %b want %b", a_vec(), 8'b0001_0011);
        end
        tick();
        nchk++;
        if (a_vec() !== 8'b0000_0011) begin
            nfail++;
            $display("FAIL tie_idle: got %b want %b", a_vec(), 8'b0000_0011);
        end
        tick();
        nchk++;
        if (a_vec() !== 8'b1011_1100) begin
            nfail++;
            $display("FAIL tie_second: got %b want %b", a_vec(), 8'b1011_1100);
        end
        a_req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int   gcount = 0;
        int   last_cyc = -1;
        int   cyc = 0;
        logic exp_g = 1'b0;
        a_req0 = 1'b1;
        a_req1 = 1'b1;
        a_din0 = 4'h5;
        a_din1 = 4'h9;
        while (gcount < 6 && cyc < 40) begin
            tick();
            cyc++;
            nchk++;
            if ({a_gnt0 & a_gnt1, a_reg_cen} !== {1'b0, a_gnt0 | a_gnt1}) begin
                nfail++;
                $display("FAIL b2b_excl: got g0=%b g1=%b cen=%b", a_gnt0, a_gnt1, a_reg_cen);
            end
            if (a_reg_cen) begin
                nchk++;
                if ({a_gnt1, a_gnt0, a_reg_pi} !== (exp_g ? 6'b10_1001 : 6'b01_0101)) begin
                    nfail++;
                    $display("FAIL b2b_grant%0d: got %b want owner %0d", gcount, {a_gnt1, a_gnt0, a_reg_pi}, exp_g);
                end
                if (last_cyc >= 0) begin
                    nchk++;
                    if (cyc - last_cyc !== 3) begin
                        nfail++;
                        $display("FAIL b2b_spacing: got %0d want 3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                exp_g = ~exp_g;
                gcount++;
            end
        end
        nchk++;
        if (gcount !== 6) begin
            nfail++;
            $display("FAIL b2b_count: got %0d want 6", gcount);
        end
        a_req0 = 1'b0;
        a_req1 = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_abort();
        a_req1 = 1'b1;
        a_din1 = 4'h6;
        tick();
        nchk++;
        if (a_vec() !== 8'b1011_0110) begin
            nfail++;
            $display("FAIL abort_wr1: got %b want %b", a_vec(), 8'b1011_0110);
        end
        rst = 1'b1;
        a_req1 = 1'b0;
        tick();
        nchk++;
        if (a_vec() !== 8'h00) begin
            nfail++;
            $display("FAIL abort_rst: got %b want %b", a_vec(), 8'h00);
        end
        rst = 1'b0;
        tick();
        nchk++;
        if (a_vec() !== 8'h00) begin
            nfail++;
            $display("FAIL abort_after: got %b want %b", a_vec(), 8'h00);
        end
        a_req0 = 1'b1;
        a_req1 = 1'b1;
        a_din0 = 4'h7;
        a_din1 = 4'h1;
        tick();
        nchk++;
        if (a_vec() !== 8'b0111_0111) begin
            nfail++;
            $display("FAIL abort_tie: got %b want %b", a_vec(), 8'b0111_0111);
        end
        a_req0 = 1'b0;
        a_req1 = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_guard0();
        b_req1 = 1'b1;
        b_din1 = 4'h2;
        tick();
        nchk++;
        if (b_vec() !== 8'b1011_0010) begin
            nfail++;
            $display("FAIL g0_wr: got %b want %b", b_vec(), 8'b1011_0010);
        end
        b_din1 = 4'hF;
        #3;
        nchk++;
        if (b_reg_pi !== 4'h2) begin
            nfail++;
            $display("FAIL g0_hold: got %h want %h", b_reg_pi, 4'h2);
        end
        tick();
        nchk++;
        if (b_vec() !== 8'b0000_0010) begin
            nfail++;
            $display("FAIL g0_idle: got %b want %b", b_vec(), 8'b0000_0010);
        end
        tick();
        nchk++;
        if (b_vec() !== 8'b1011_1111) begin
            nfail++;
            $display("FAIL g0_next: got %b want %b", b_vec(), 8'b1011_1111);
        end
        b_req1 = 1'b0;
        tick();
        tick();
        nchk++;
        if (b_vec() !== 8'b0000_1111) begin
            nfail++;
            $display("FAIL g0_end: got %b want %b", b_vec(), 8'b0000_1111);
        end
    endtask

`ifdef REG4_ARB_WRCOUNT_EN
    task automatic test_wrcount();
        int n = 0;
        int cyc = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nchk++;
        if (b_wr_count !== 8'd0) begin
            nfail++;
            $display("FAIL wrcnt_reset: got %0d want 0", b_wr_count);
        end
        b_req0 = 1'b1;
        b_din0 = 4'h4;
        while (n < 257 && cyc < 1000) begin
            tick();
            cyc++;
            if (b_gnt0) n++;
        end
        b_req0 = 1'b0;
        tick();
        tick();
        nchk++;
        if (n !== 257) begin
            nfail++;
            $display("FAIL wrcnt_writes: got %0d want 257", n);
        end
        nchk++;
        if (b_wr_count !== 8'd1) begin
            nfail++;
            $display("FAIL wrcnt_wrap: got %0d want 1", b_wr_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        a_req0 = 1'b0; a_req1 = 1'b0; a_din0 = 4'h0; a_din1 = 4'h0;
        b_req0 = 1'b0; b_req1 = 1'b0; b_din0 = 4'h0; b_din1 = 4'h0;
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_reset_abort();
        test_guard0();
`ifdef REG4_ARB_WRCOUNT_EN
        test_wrcount();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
